// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART receiver and its companion transmitter:
// the receiver state encoding and the input synchronizer depth.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_BRK_WAIT = 3'd5
    } uart_state_e;

    // Number of flops between the raw rx pin and any decision logic.
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/uart_baud_timer.sv
// Down-counting bit-period timer shared by the UART receiver and transmitter.
// A load strobe sets the count; the tick output is high while the count is zero.
// The counter parks at zero rather than wrapping, so the owner reloads it explicitly.
module uart_baud_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver with framing, overrun and break detection and a
// ready/valid holding register towards the consumer.
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit after the data bits).
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = 6,
    parameter int DATA_BITS       = 8,
    parameter int STOP_BITS       = 1,
    parameter int PARITY_ODD      = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o,
    output logic                 break_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(CLOCKS_PER_BAUD);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LD_HALF   = CNT_W'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [CNT_W-1:0] LD_FULL   = CNT_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    if (CLOCKS_PER_BAUD < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_rx_framed: parameter out of range");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx;
    uart_state_e            r_state;
    uart_state_e            w_next;
    logic                   w_tick;
    logic                   w_load;
    logic [CNT_W-1:0]       w_load_val;
    logic [BIT_W-1:0]       r_bit_cnt;
    logic                   r_stop_cnt;
    logic                   r_ferr;
    logic                   r_stop0_low;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   w_sample_data;
    logic                   w_sample_stop;
    logic                   w_done;
    logic                   w_brk;
    logic                   w_commit;
    logic                   w_ferr_final;
    logic                   w_first_stop_low;
    logic                   w_par_zero;
    logic                   w_perr;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = 1'(PARITY_ODD);
    logic                   w_sample_par;
    logic                   r_par;
`endif

    // Two-flop synchronizer on the raw serial input; idles high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign w_rx = r_sync[SYNC_STAGES-1];

    uart_baud_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_load    (w_load),
        .i_load_val(w_load_val),
        .o_tick    (w_tick)
    );

    // First stop bit: live sample on the first stop tick, remembered afterwards.
    assign w_first_stop_low = (r_stop_cnt == 1'b0) ? !w_rx : r_stop0_low;
    assign w_ferr_final     = r_ferr | !w_rx;
`ifdef UART_RX_PARITY_EN
    assign w_par_zero = !r_par;
    assign w_perr     = r_par ^ (^r_shift) ^ PAR_ODD;
`else
    assign w_par_zero = 1'b1;
    assign w_perr     = 1'b0;
`endif
    assign w_brk    = (r_shift == '0) && w_par_zero && w_first_stop_low;
    assign w_commit = w_done && !w_brk;

    // Receiver state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode, bit-timer reloads and sample strobes.
    always_comb begin
        w_next        = r_state;
        w_load        = 1'b0;
        w_load_val    = LD_FULL;
        w_sample_data = 1'b0;
        w_sample_stop = 1'b0;
        w_done        = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_sample_par  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!w_rx) begin
                    w_next     = ST_START;
                    w_load     = 1'b1;
                    w_load_val = LD_HALF;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (w_rx) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_next = ST_DATA;
                        w_load = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_sample_data = 1'b1;
                    w_load        = 1'b1;
                    if (r_bit_cnt == '0) begin
`ifdef UART_RX_PARITY_EN
                        w_next = ST_PARITY;
`else
                        w_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_sample_par = 1'b1;
                    w_load       = 1'b1;
                    w_next       = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    w_sample_stop = 1'b1;
                    if (r_stop_cnt == STOP_LAST) begin
                        w_done = 1'b1;
                        w_next = w_brk ? ST_BRK_WAIT : ST_IDLE;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            ST_BRK_WAIT: begin
                if (w_rx) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Bit and stop counters plus per-frame stop-bit status; rearmed while in START.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt   <= '0;
            r_stop_cnt  <= 1'b0;
            r_ferr      <= 1'b0;
            r_stop0_low <= 1'b0;
        end else if (r_state == ST_START) begin
            r_bit_cnt   <= BIT_LAST;
            r_stop_cnt  <= 1'b0;
            r_ferr      <= 1'b0;
            r_stop0_low <= 1'b0;
        end else begin
            if (w_sample_data) begin
                r_bit_cnt <= r_bit_cnt - 1'b1;
            end
            if (w_sample_stop) begin
                r_stop_cnt <= r_stop_cnt + 1'b1;
                if (!w_rx) begin
                    r_ferr <= 1'b1;
                end
                if (r_stop_cnt == 1'b0) begin
                    r_stop0_low <= !w_rx;
                end
            end
        end
    end

    // Data shift register: LSB arrives first, so shift right and insert at the MSB.
    always_ff @(posedge clock) begin
        if (w_sample_data) begin
            r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
        end
`ifdef UART_RX_PARITY_EN
        if (w_sample_par) begin
            r_par <= w_rx;
        end
`endif
    end

    // Holding register, handshake, overrun and break pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_o       <= '0;
            valid_o      <= 1'b0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
            overrun_o    <= 1'b0;
            break_o      <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            break_o   <= w_done && w_brk;
            if (w_commit) begin
                if (!valid_o || ready_i) begin
                    data_o       <= r_shift;
                    valid_o      <= 1'b1;
                    frame_err_o  <= w_ferr_final;
                    parity_err_o <= w_perr;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o      <= 1'b0;
                frame_err_o  <= 1'b0;
                parity_err_o <= 1'b0;
            end
        end
    end

    assign busy_o = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed testbench for uart_rx_framed (CPB=6, 8 data bits, 1 stop bit).
// Build with UART_RX_PARITY_EN defined to include the parity scenario.
module tb_uart_rx_framed;

    localparam int CPB  = 6;
    localparam int DBITS = 8;
    localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
    localparam int PBIT = 1;
`else
    localparam int PBIT = 0;
`endif
    // Posedges from driving the start bit until valid_o is visible:
    // 2 synchronizer edges + CPB/2 + (DATA+P+STOP)*CPB + 1.
    localparam int LAT = 2 + CPB / 2 + (DBITS + PBIT + 1) * CPB + 1;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             rx_i = 1'b1;
    logic             ready_i = 1'b1;
    logic [DBITS-1:0] data_o;
    logic             valid_o;
    logic             frame_err_o;
    logic             parity_err_o;
    logic             overrun_o;
    logic             break_o;
    logic             busy_o;

    int checks = 0;
    int errors = 0;
    int brk_pulses = 0;
    int ovr_pulses = 0;
    int valid_cycles = 0;

    uart_rx_framed #(
        .CLOCKS_PER_BAUD(CPB),
        .DATA_BITS      (DBITS),
        .STOP_BITS      (1),
        .PARITY_ODD     (PODD)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .parity_err_o(parity_err_o),
        .overrun_o   (overrun_o),
        .break_o     (break_o),
        .busy_o      (busy_o)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (break_o)   brk_pulses   <= brk_pulses + 1;
        if (overrun_o) ovr_pulses   <= ovr_pulses + 1;
        if (valid_o)   valid_cycles <= valid_cycles + 1;
    end

    // Drive one frame starting at a negedge; returns on the negedge after the stop bit.
    task automatic send_frame(input logic [DBITS-1:0] d, input logic stop_v, input logic par_flip);
        rx_i = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < DBITS; i++) begin
            rx_i = d[i];
            repeat (CPB) @(negedge clock);
        end
`ifdef UART_RX_PARITY_EN
        rx_i = (^d) ^ 1'(PODD) ^ par_flip;
        repeat (CPB) @(negedge clock);
`else
        if (par_flip) rx_i = 1'b1;
`endif
        rx_i = stop_v;
        repeat (CPB) @(negedge clock);
        rx_i = 1'b1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data_o); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", frame_err_o); end
        checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b exp=0", parity_err_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_ovr got=%b exp=0", overrun_o); end
        checks++; if (break_o !== 1'b0) begin errors++; $display("FAIL reset_brk got=%b exp=0", break_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        reset_n = 1'b1;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic test_basic_latency;
        ready_i = 1'b1;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                repeat (LAT - 1) @(posedge clock);
                #1;
                checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL lat_early_valid got=%b exp=0", valid_o); end
                @(posedge clock); #1;
                checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL lat_valid got=%b exp=1", valid_o); end
                checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL a5_data got=%h exp=a5", data_o); end
                checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL a5_ferr got=%b exp=0", frame_err_o); end
                checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL a5_perr got=%b exp=0", parity_err_o); end
                @(posedge clock); #1;
                checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL a5_one_cycle got=%b exp=0", valid_o); end
            end
        join
        repeat (CPB) @(negedge clock);
    endtask

    task automatic test_frame_error;
        int b0;
        b0 = brk_pulses;
        ready_i = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0);
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL ferr_valid got=%b exp=1", valid_o); end
        checks++; if (data_o !== 8'h3C) begin errors++; $display("FAIL ferr_data got=%h exp=3c", data_o); end
        checks++; if (frame_err_o !== 1'b1) begin errors++; $display("FAIL ferr_flag got=%b exp=1", frame_err_o); end
        @(negedge clock);
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL ferr_clear got=%b exp=0", frame_err_o); end
        repeat (CPB) @(negedge clock);
        checks++; if (brk_pulses - b0 !== 0) begin errors++; $display("FAIL ferr_no_break got=%0d exp=0", brk_pulses - b0); end
    endtask

    task automatic test_break;
        int b0;
        int v0;
        b0 = brk_pulses;
        v0 = valid_cycles;
        ready_i = 1'b1;
        rx_i = 1'b0;
        repeat (12 * CPB) @(negedge clock);
        rx_i = 1'b1;
        repeat (3 * CPB) @(negedge clock);
        checks++; if (brk_pulses - b0 !== 1) begin errors++; $display("FAIL break_pulses got=%0d exp=1", brk_pulses - b0); end
        checks++; if (valid_cycles - v0 !== 0) begin errors++; $display("FAIL break_valid got=%0d exp=0", valid_cycles - v0); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL break_busy got=%b exp=0", busy_o); end
        send_frame(8'h55, 1'b1, 1'b0);
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL post_break_valid got=%b exp=1", valid_o); end
        checks++; if (data_o !== 8'h55) begin errors++; $display("FAIL post_break_data got=%h exp=55", data_o); end
        repeat (CPB) @(negedge clock);
    endtask

    task automatic test_overrun;
        int o0;
        ready_i = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL ovr_first_valid got=%b exp=1", valid_o); end
        checks++; if (data_o !== 8'h11) begin errors++; $display("FAIL ovr_first_data got=%h exp=11", data_o); end
        repeat (CPB) @(negedge clock);
        o0 = ovr_pulses;
        send_frame(8'h22, 1'b1, 1'b0);
        @(negedge clock);
        checks++; if (ovr_pulses - o0 !== 1) begin errors++; $display("FAIL ovr_pulse got=%0d exp=1", ovr_pulses - o0); end
        checks++; if (data_o !== 8'h11) begin errors++; $display("FAIL ovr_held_data got=%h exp=11", data_o); end
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL ovr_held_valid got=%b exp=1", valid_o); end
        ready_i = 1'b1;
        @(negedge clock);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL ovr_drain got=%b exp=0", valid_o); end
        repeat (CPB) @(negedge clock);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        ready_i = 1'b1;
        send_frame(8'h07, 1'b1, 1'b1);
        checks++; if (parity_err_o !== 1'b1) begin errors++; $display("FAIL par_bad got=%b exp=1", parity_err_o); end
        checks++; if (data_o !== 8'h07) begin errors++; $display("FAIL par_bad_data got=%h exp=07", data_o); end
        repeat (CPB) @(negedge clock);
        send_frame(8'h07, 1'b1, 1'b0);
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL par_good_valid got=%b exp=1", valid_o); end
        checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL par_good got=%b exp=0", parity_err_o); end
        repeat (CPB) @(negedge clock);
    endtask
`endif

    task automatic test_glitch_and_reset;
        int v0;
        v0 = valid_cycles;
        rx_i = 1'b0;
        repeat (2) @(negedge clock);
        rx_i = 1'b1;
        @(negedge clock);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL glitch_busy_set got=%b exp=1", busy_o); end
        repeat (10) @(negedge clock);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL glitch_busy_clear got=%b exp=0", busy_o); end
        checks++; if (valid_cycles - v0 !== 0) begin errors++; $display("FAIL glitch_valid got=%0d exp=0", valid_cycles - v0); end
        // Start a frame and reset inside its data bits.
        rx_i = 1'b0;
        repeat (CPB) @(negedge clock);
        rx_i = 1'b1;
        repeat (CPB) @(negedge clock);
        rx_i = 1'b0;
        repeat (CPB) @(negedge clock);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_frame_busy got=%b exp=1", busy_o); end
        reset_n = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL rst_data got=%h exp=00", data_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", valid_o); end
        rx_i = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (CPB) @(negedge clock);
        ready_i = 1'b1;
        send_frame(8'h96, 1'b1, 1'b0);
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL rst_next_valid got=%b exp=1", valid_o); end
        checks++; if (data_o !== 8'h96) begin errors++; $display("FAIL rst_next_data got=%h exp=96", data_o); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL rst_next_ferr got=%b exp=0", frame_err_o); end
        repeat (CPB) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_frame_error();
        test_break();
        test_overrun();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_glitch_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
